// File: rtl/tpu_seq_ctrl.sv
// GEMM command sequencer for the TPU core: streams B weights, A rows and C bias
// rows out of the input buffer and counts result writebacks until completion.
module tpu_seq_ctrl #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int ADDR_WIDTH           = 10,
  parameter int C_DELAY              = 18
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                  cmd_a_base,
  input  logic [ADDR_WIDTH-1:0]                  cmd_b_base,
  input  logic [ADDR_WIDTH-1:0]                  cmd_c_base,
  input  logic [ADDR_WIDTH-1:0]                  cmd_d_base,
  input  logic [ADDR_WIDTH-1:0]                  cmd_m_rows,
  input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0]  cmd_k_dim,
  input  logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0]  cmd_n_dim,
  input  logic [2:0]                             cmd_vpu_mode,
  output logic [ADDR_WIDTH-1:0]                  ctrl_rd_addr_a,
  output logic                                   ctrl_rd_en_a,
  output logic                                   ctrl_a_valid,
  output logic                                   ctrl_a_switch,
  output logic [ADDR_WIDTH-1:0]                  ctrl_rd_addr_b,
  output logic                                   ctrl_rd_en_b,
  output logic                                   ctrl_b_accept_w,
  output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
  output logic [ADDR_WIDTH-1:0]                  ctrl_rd_addr_c,
  output logic                                   ctrl_rd_en_c,
  output logic [2:0]                             ctrl_vpu_mode,
  output logic [ADDR_WIDTH-1:0]                  ctrl_wr_addr_d,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]        ctrl_row_mask,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]        ctrl_col_mask,
  input  logic                                   core_writeback_valid,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   cmd_err,
  output logic [2:0]                             dbg_state
);
  localparam int W  = SYSTOLIC_ARRAY_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int IW = $clog2(W);
  localparam int KW = IW + 1;
  localparam int DW = $clog2(C_DELAY + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ERR      = 3'd1,
    S_LOAD_W   = 3'd2,
    S_STREAM_A = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] a_base_q, b_base_q, c_base_q, d_base_q, m_q;
  logic [KW-1:0] k_q, i_q;
  logic [AW-1:0] r_q, w_q, c_r_q;
  logic [DW-1:0] c_dly_q;
  logic          c_wait_q, c_run_q, c_fin_q;
  logic [AW-1:0] hold_a_q, hold_b_q, hold_c_q;
  logic          accept_w_q, a_valid_q, a_switch_q;
  logic [IW-1:0] w_idx_q;
  logic [W-1:0]  row_mask_q, col_mask_q;
  logic [2:0]    vpu_q;

  logic accept, cmd_ok, last_i, last_r, last_c, fin;

  function automatic logic [W-1:0] lsb_mask(input logic [KW-1:0] cnt);
    logic [W-1:0] m;
    for (int j = 0; j < W; j++) m[j] = (j < int'(cnt));
    return m;
  endfunction

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and every cmd_* field is sampled on that edge.
  assign accept = cmd_valid && cmd_ready;
  assign cmd_ok = (cmd_m_rows != '0) && (cmd_k_dim != '0) && (cmd_k_dim <= KW'(W)) &&
                  (cmd_n_dim != '0) && (cmd_n_dim <= KW'(W));
  assign last_i = (i_q == k_q - KW'(1));
  assign last_r = (r_q == m_q - AW'(1));
  assign last_c = (c_r_q == m_q - AW'(1));
  assign fin    = (state_q == S_DRAIN) && (w_q == m_q) && c_fin_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = cmd_ok ? S_LOAD_W : S_ERR;
      S_ERR:      state_d = S_IDLE;
      S_LOAD_W:   if (last_i) state_d = S_STREAM_A;
      S_STREAM_A: if (last_r) state_d = S_DRAIN;
      S_DRAIN:    if (fin) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    cmd_err      = 1'b0;
    ctrl_rd_en_b = 1'b0;
    ctrl_rd_en_a = 1'b0;
    case (state_q)
      S_IDLE:     cmd_ready = 1'b1;
      S_ERR:      begin done = 1'b1; cmd_err = 1'b1; end
      S_LOAD_W:   begin busy = 1'b1; ctrl_rd_en_b = 1'b1; end
      S_STREAM_A: begin busy = 1'b1; ctrl_rd_en_a = 1'b1; end
      S_DRAIN:    begin busy = 1'b1; done = fin; end
      default:    ;
    endcase
    ctrl_rd_en_c        = c_run_q;
    // Addresses track the live counter inside a window and freeze afterwards.
    ctrl_rd_addr_b      = ctrl_rd_en_b ? b_base_q + AW'(i_q) : hold_b_q;
    ctrl_rd_addr_a      = ctrl_rd_en_a ? a_base_q + r_q : hold_a_q;
    ctrl_rd_addr_c      = ctrl_rd_en_c ? c_base_q + c_r_q : hold_c_q;
    ctrl_wr_addr_d      = d_base_q + w_q;
    ctrl_b_accept_w     = accept_w_q;
    ctrl_b_weight_index = w_idx_q;
    ctrl_a_valid        = a_valid_q;
    ctrl_a_switch       = a_switch_q;
    ctrl_row_mask       = row_mask_q;
    ctrl_col_mask       = col_mask_q;
    ctrl_vpu_mode       = vpu_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      d_base_q   <= '0;
      m_q        <= '0;
      k_q        <= '0;
      i_q        <= '0;
      r_q        <= '0;
      w_q        <= '0;
      c_r_q      <= '0;
      c_dly_q    <= '0;
      c_wait_q   <= 1'b0;
      c_run_q    <= 1'b0;
      c_fin_q    <= 1'b0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      hold_c_q   <= '0;
      accept_w_q <= 1'b0;
      w_idx_q    <= '0;
      a_valid_q  <= 1'b0;
      a_switch_q <= 1'b0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      vpu_q      <= '0;
    end else begin
      // Buffer reads return one cycle after the strobe.
      accept_w_q <= ctrl_rd_en_b;
      w_idx_q    <= i_q[IW-1:0];
      a_valid_q  <= ctrl_rd_en_a;
      a_switch_q <= ctrl_rd_en_a && (r_q == '0);
      if (ctrl_rd_en_b) hold_b_q <= ctrl_rd_addr_b;
      if (ctrl_rd_en_a) hold_a_q <= ctrl_rd_addr_a;
      if (ctrl_rd_en_c) hold_c_q <= ctrl_rd_addr_c;
      if (accept) begin
        a_base_q <= cmd_a_base;
        b_base_q <= cmd_b_base;
        c_base_q <= cmd_c_base;
        d_base_q <= cmd_d_base;
        m_q      <= cmd_m_rows;
        k_q      <= cmd_k_dim;
        i_q      <= '0;
        r_q      <= '0;
        w_q      <= '0;
        c_r_q    <= '0;
        c_dly_q  <= '0;
        c_wait_q <= 1'b0;
        c_run_q  <= 1'b0;
        c_fin_q  <= 1'b0;
        if (cmd_ok) begin
          row_mask_q <= lsb_mask(cmd_k_dim);
          col_mask_q <= lsb_mask(cmd_n_dim);
          vpu_q      <= cmd_vpu_mode;
        end
      end else begin
        if (ctrl_rd_en_b && !last_i) i_q <= i_q + 1'b1;
        if (ctrl_rd_en_a && !last_r) r_q <= r_q + 1'b1;
        if (busy && core_writeback_valid && (w_q != m_q)) w_q <= w_q + 1'b1;
        // C flow is timed from the first A strobe, independent of the FSM.
        if (ctrl_rd_en_a && (r_q == '0)) begin
          if (C_DELAY == 1) begin
            c_run_q <= 1'b1;
          end else begin
            c_wait_q <= 1'b1;
            c_dly_q  <= DW'(1);
          end
        end
        if (c_wait_q) begin
          if (c_dly_q == DW'(C_DELAY - 1)) begin
            c_wait_q <= 1'b0;
            c_run_q  <= 1'b1;
          end else begin
            c_dly_q <= c_dly_q + 1'b1;
          end
        end
        if (c_run_q) begin
          if (last_c) begin
            c_run_q <= 1'b0;
            c_fin_q <= 1'b1;
          end else begin
            c_r_q <= c_r_q + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl: cycle-by-cycle strobe and address checks
// against hand-derived timing for each command scenario.
module tb_tpu_seq_ctrl;
  localparam int W  = 16;
  localparam int AW = 10;
  localparam int CD = 18;
  localparam int IW = $clog2(W);
  localparam int KW = IW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_a_base, cmd_b_base, cmd_c_base, cmd_d_base, cmd_m_rows;
  logic [KW-1:0] cmd_k_dim, cmd_n_dim;
  logic [2:0]    cmd_vpu_mode;
  logic [AW-1:0] ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d;
  logic          ctrl_rd_en_a, ctrl_a_valid, ctrl_a_switch;
  logic          ctrl_rd_en_b, ctrl_b_accept_w, ctrl_rd_en_c;
  logic [IW-1:0] ctrl_b_weight_index;
  logic [2:0]    ctrl_vpu_mode;
  logic [W-1:0]  ctrl_row_mask, ctrl_col_mask;
  logic          core_writeback_valid;
  logic          busy, done, cmd_err;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_row, last_col;
  logic [2:0]   last_mode;

  // clock / reset
  always #5 clk = ~clk;

  tpu_seq_ctrl #(.SYSTOLIC_ARRAY_WIDTH(W), .ADDR_WIDTH(AW), .C_DELAY(CD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
    .cmd_d_base(cmd_d_base), .cmd_m_rows(cmd_m_rows), .cmd_k_dim(cmd_k_dim),
    .cmd_n_dim(cmd_n_dim), .cmd_vpu_mode(cmd_vpu_mode),
    .ctrl_rd_addr_a(ctrl_rd_addr_a), .ctrl_rd_en_a(ctrl_rd_en_a),
    .ctrl_a_valid(ctrl_a_valid), .ctrl_a_switch(ctrl_a_switch),
    .ctrl_rd_addr_b(ctrl_rd_addr_b), .ctrl_rd_en_b(ctrl_rd_en_b),
    .ctrl_b_accept_w(ctrl_b_accept_w), .ctrl_b_weight_index(ctrl_b_weight_index),
    .ctrl_rd_addr_c(ctrl_rd_addr_c), .ctrl_rd_en_c(ctrl_rd_en_c),
    .ctrl_vpu_mode(ctrl_vpu_mode), .ctrl_wr_addr_d(ctrl_wr_addr_d),
    .ctrl_row_mask(ctrl_row_mask), .ctrl_col_mask(ctrl_col_mask),
    .core_writeback_valid(core_writeback_valid), .busy(busy), .done(done),
    .cmd_err(cmd_err), .dbg_state(dbg_state)
  );

  // Packed view: {en_b, accept_w, en_a, a_valid, a_switch, en_c, done, cmd_err, busy, cmd_ready}
  function automatic logic [9:0] strobes();
    return {ctrl_rd_en_b, ctrl_b_accept_w, ctrl_rd_en_a, ctrl_a_valid, ctrl_a_switch,
            ctrl_rd_en_c, done, cmd_err, busy, cmd_ready};
  endfunction

  task automatic drive_cmd(input logic [AW-1:0] a, b, c, d, m, input logic [KW-1:0] k, n,
                           input logic [2:0] mode);
    cmd_a_base = a; cmd_b_base = b; cmd_c_base = c; cmd_d_base = d;
    cmd_m_rows = m; cmd_k_dim = k; cmd_n_dim = n; cmd_vpu_mode = mode;
    cmd_valid = 1'b1;
  endtask

  // Runs one valid command from IDLE to IDLE, checking every cycle.
  task automatic run_gemm(input logic [AW-1:0] a, b, c, d, m, input logic [KW-1:0] k, n,
                          input logic [2:0] mode, input int max_gap, input bit hold_valid);
    int ki, mi, t_end, gap, x;
    logic [9:0] exp_s, act_s;
    logic [AW-1:0] e_addr;
    logic [W-1:0] e_row, e_col;
    ki = int'(k);
    mi = int'(m);
    t_end = ki + CD + mi + 1;
    e_row = W'((32'd1 << ki) - 1);
    e_col = W'((32'd1 << int'(n)) - 1);
    @(negedge clk);
    drive_cmd(a, b, c, d, m, k, n, mode);
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      if (!hold_valid) cmd_valid = 1'b0;
      exp_s = {(t <= ki), (t >= 2 && t <= ki + 1), (t >= ki + 1 && t <= ki + mi),
               (t >= ki + 2 && t <= ki + mi + 1), (t == ki + 2),
               (t >= ki + 1 + CD && t <= ki + CD + mi), 1'b0, 1'b0, 1'b1, 1'b0};
      act_s = strobes();
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL strobes t=%0d: got %b expected %b", t, act_s, exp_s);
      end
      x = (t < ki) ? t : ki;
      e_addr = b + AW'(x - 1);
      checks++;
      if (ctrl_rd_addr_b !== e_addr) begin
        errors++;
        $display("FAIL rd_addr_b t=%0d: got %0d expected %0d", t, ctrl_rd_addr_b, e_addr);
      end
      if (t >= 2 && t <= ki + 1) begin
        checks++;
        if (ctrl_b_weight_index !== IW'(t - 2)) begin
          errors++;
          $display("FAIL weight_index t=%0d: got %0d expected %0d", t, ctrl_b_weight_index, t - 2);
        end
      end
      if (t > ki) begin
        x = (t - ki - 1 < mi - 1) ? t - ki - 1 : mi - 1;
        e_addr = a + AW'(x);
        checks++;
        if (ctrl_rd_addr_a !== e_addr) begin
          errors++;
          $display("FAIL rd_addr_a t=%0d: got %0d expected %0d", t, ctrl_rd_addr_a, e_addr);
        end
      end
      if (t > ki + CD) begin
        x = (t - ki - 1 - CD < mi - 1) ? t - ki - 1 - CD : mi - 1;
        e_addr = c + AW'(x);
        checks++;
        if (ctrl_rd_addr_c !== e_addr) begin
          errors++;
          $display("FAIL rd_addr_c t=%0d: got %0d expected %0d", t, ctrl_rd_addr_c, e_addr);
        end
      end
      checks++;
      if (ctrl_wr_addr_d !== d) begin
        errors++;
        $display("FAIL wr_addr_d t=%0d: got %0d expected %0d", t, ctrl_wr_addr_d, d);
      end
      if (t == 1) begin
        checks++;
        if ({ctrl_row_mask, ctrl_col_mask, ctrl_vpu_mode} !== {e_row, e_col, mode}) begin
          errors++;
          $display("FAIL masks: got row %h col %h mode %0d expected row %h col %h mode %0d",
                   ctrl_row_mask, ctrl_col_mask, ctrl_vpu_mode, e_row, e_col, mode);
        end
      end
    end
    for (int wi = 0; wi < mi; wi++) begin
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) begin
        @(negedge clk);
        e_addr = d + AW'(wi);
        checks++;
        if ({done, busy, ctrl_wr_addr_d} !== {1'b0, 1'b1, e_addr}) begin
          errors++;
          $display("FAIL wb_gap w=%0d: got done %b busy %b addr %0d expected 0 1 %0d",
                   wi, done, busy, ctrl_wr_addr_d, e_addr);
        end
      end
      core_writeback_valid = 1'b1;
      @(negedge clk);
      core_writeback_valid = 1'b0;
      e_addr = d + AW'(wi + 1);
      checks++;
      if ({done, cmd_err, busy, ctrl_wr_addr_d} !== {(wi + 1 == mi), 1'b0, 1'b1, e_addr}) begin
        errors++;
        $display("FAIL wb_done w=%0d: got done %b err %b busy %b addr %0d expected %b 0 1 %0d",
                 wi + 1, done, cmd_err, busy, ctrl_wr_addr_d, (wi + 1 == mi), e_addr);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({strobes(), dbg_state} !== {10'b0000000001, 3'd0}) begin
      errors++;
      $display("FAIL after_done: got %b state %0d expected 0000000001 state 0", strobes(), dbg_state);
    end
    checks++;
    if ({ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c} !==
        {AW'(a + m - 1), AW'(b + AW'(ki - 1)), AW'(c + m - 1)}) begin
      errors++;
      $display("FAIL held_addr: got a %0d b %0d c %0d", ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c);
    end
    last_row = e_row;
    last_col = e_col;
    last_mode = mode;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({strobes(), ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d,
           ctrl_row_mask, ctrl_col_mask, ctrl_b_weight_index, ctrl_vpu_mode, dbg_state} !==
          {10'b0000000001, 40'd0, 32'd0, 4'd0, 3'd0, 3'd0}) begin
        errors++;
        $display("FAIL reset phase %0d: strobes %b addr_a %0d addr_d %0d masks %h/%h state %0d",
                 p, strobes(), ctrl_rd_addr_a, ctrl_wr_addr_d, ctrl_row_mask, ctrl_col_mask, dbg_state);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    drive_cmd(10'd100, 10'd200, 10'd300, 10'd400, 10'd6, 5'd2, 5'd2, 3'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl_rd_en_a, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mid_stream_active: got en_a %b busy %b expected 1 1", ctrl_rd_en_a, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({strobes(), ctrl_row_mask, dbg_state} !== {10'b0000000001, 16'd0, 3'd0}) begin
      errors++;
      $display("FAIL mid_stream_reset: got %b mask %h state %0d expected 0000000001 0000 0",
               strobes(), ctrl_row_mask, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_idle: got ready %b busy %b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_gemm(10'd0, 10'd16, 10'd32, 10'd48, 10'd5, 5'd4, 5'd3, 3'd5, 0, 1'b0);
  endtask

  task automatic test_idle_writeback();
    for (int p = 0; p < 3; p++) begin
      core_writeback_valid = 1'b1;
      @(negedge clk);
      core_writeback_valid = 1'b0;
      checks++;
      if ({ctrl_wr_addr_d, done, cmd_ready, busy} !== {10'd53, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL idle_wb %0d: got addr %0d done %b ready %b busy %b expected 53 0 1 0",
                 p, ctrl_wr_addr_d, done, cmd_ready, busy);
      end
    end
  endtask

  task automatic test_addr_wrap();
    run_gemm(10'd1022, 10'd1023, 10'd1021, 10'd1023, 10'd4, 5'd2, 5'd16, 3'd2, 3, 1'b0);
  endtask

  task automatic test_invalid();
    int tm[5] = '{5, 0, 5, 5, 5};
    int tk[5] = '{3, 3, 0, 17, 3};
    int tn[5] = '{0, 3, 3, 3, 17};
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      drive_cmd(10'd7, 10'd8, 10'd9, 10'd10, AW'(tm[v]), KW'(tk[v]), KW'(tn[v]), 3'd6);
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if ({strobes(), dbg_state} !== {10'b0000001100, 3'd1}) begin
        errors++;
        $display("FAIL invalid_err v=%0d: got %b state %0d expected 0000001100 state 1",
                 v, strobes(), dbg_state);
      end
      checks++;
      if ({ctrl_row_mask, ctrl_col_mask, ctrl_vpu_mode} !== {last_row, last_col, last_mode}) begin
        errors++;
        $display("FAIL invalid_masks v=%0d: got %h %h %0d expected %h %h %0d", v,
                 ctrl_row_mask, ctrl_col_mask, ctrl_vpu_mode, last_row, last_col, last_mode);
      end
      @(negedge clk);
      checks++;
      if (strobes() !== 10'b0000000001) begin
        errors++;
        $display("FAIL invalid_idle v=%0d: got %b expected 0000000001", v, strobes());
      end
    end
  endtask

  task automatic test_hold_valid();
    run_gemm(10'd500, 10'd600, 10'd700, 10'd800, 10'd3, 5'd3, 5'd4, 3'd3, 2, 1'b1);
  endtask

  task automatic test_writeback_gaps();
    run_gemm(10'd40, 10'd50, 10'd60, 10'd70, 10'd6, 5'd16, 5'd1, 3'd7, 7, 1'b0);
  endtask

  initial begin
    cmd_valid = 1'b0;
    core_writeback_valid = 1'b0;
    cmd_a_base = '0; cmd_b_base = '0; cmd_c_base = '0; cmd_d_base = '0;
    cmd_m_rows = '0; cmd_k_dim = '0; cmd_n_dim = '0; cmd_vpu_mode = '0;
    last_row = '0; last_col = '0; last_mode = '0;
    test_reset();
    test_reset_mid_stream();
    test_basic();
    test_idle_writeback();
    test_addr_wrap();
    test_invalid();
    test_hold_valid();
    test_writeback_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
- Sequencer for the TPU core datapath. Accepts one GEMM command (D = f(A·B + C)) over a valid/ready handshake.
- Drives the core's Input Buffer read ports for the B (weight), A (input) and C (bias) flows, the global valid/switch/accept/index controls, the row/column masks and the Output Buffer write address.
- Counts core_writeback_valid pulses to detect completion. Sits between the host/register front-end and the TPU core.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension W.
- ADDR_WIDTH, 10, buffer address width.
- C_DELAY, 18, cycles from the first A read strobe to the first C read strobe (L). Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, can accept
- cmd_a_base, cmd_b_base, cmd_c_base, cmd_d_base  in  ADDR_WIDTH each  base row addresses
- cmd_m_rows  in  ADDR_WIDTH  number of A/C/D rows (M)
- cmd_k_dim  in  $clog2(W)+1  K (1..W)
- cmd_n_dim  in  $clog2(W)+1  N (1..W)
- cmd_vpu_mode  in  3  VPU mode
- ctrl_rd_addr_a / ctrl_rd_en_a  out  ADDR_WIDTH / 1  A read
- ctrl_a_valid, ctrl_a_switch  out  1 each  A global controls
- ctrl_rd_addr_b / ctrl_rd_en_b  out  ADDR_WIDTH / 1  B read
- ctrl_b_accept_w  out  1  weight accept
- ctrl_b_weight_index  out  $clog2(W)  weight row index
- ctrl_rd_addr_c / ctrl_rd_en_c  out  ADDR_WIDTH / 1  C read
- ctrl_vpu_mode  out  3  latched mode
- ctrl_wr_addr_d  out  ADDR_WIDTH  result write address
- ctrl_row_mask, ctrl_col_mask  out  W each  K/N enable masks
- core_writeback_valid  in  1  one aligned result row written this cycle
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  qualifies done: command rejected

Behaviour:
- Reset (async, any state): FSM→IDLE. cmd_ready=1. All other outputs 0, masks 0, counters 0.
- Handshake: accept when cmd_valid&&cmd_ready. All cmd_* fields latched that edge. cmd_ready=0 whenever not IDLE.
- Masks: row_mask=(1<<K)-1, col_mask=(1<<N)-1. Set from the accept edge, held until the next accept. vpu_mode is held likewise.
- Invalid command (M==0, K==0, K>W, N==0 or N>W): IDLE→ERR for 1 cycle. done=1 and cmd_err=1 in that cycle, then IDLE. No read/write strobes. Masks not updated.
- IDLE→LOAD_W on a valid accept. busy=1 from the next cycle until the cycle after done.
- LOAD_W, K cycles, i=0..K-1:
  - rd_en_b=1, rd_addr_b=b_base+i.
  - One cycle later (buffer read latency 1): accept_w=1, weight_index=i.
- →STREAM_A, M cycles, r=0..M-1:
  - rd_en_a=1, rd_addr_a=a_base+r.
  - One cycle later: a_valid=1. a_switch=1 only with the first valid row (r=0).
  - The last accept_w and the first rd_en_a may share a cycle.
- C flow runs as an independent sub-counter, not a state:
  - First rd_en_c occurs exactly C_DELAY cycles after the first rd_en_a.
  - Then M consecutive cycles, rd_addr_c=c_base+r.
  - May overlap STREAM_A and DRAIN.
- →DRAIN after the last A strobe.
- Write counter w (0..M), active LOAD_W through DRAIN:
  - ctrl_wr_addr_d=d_base+w combinationally.
  - w increments on each core_writeback_valid. Writebacks in IDLE are ignored.
- When w reaches M and the C sub-counter has finished: done=1 (cmd_err=0) that cycle, FSM→IDLE.
- All address arithmetic wraps modulo 2^ADDR_WIDTH.
- Read enables are 0 outside their windows, and their addresses hold their last value.

Test Plan:
- Reset mid-STREAM_A: assert rst → same cycle all strobes 0, cmd_ready=1, busy=0. A new command then runs normally.
- K=4, N=3, M=5, bases 0/16/32/48 → rd_en_b at 16..19, accept_w with index 0..3 one cycle later. rd_en_a at 0..4. a_switch once. col_mask=0x0007, row_mask=0x000F.
- Same command, count cycles → first rd_en_c exactly C_DELAY=18 cycles after the first rd_en_a, addresses 32..36. Five writebacks at addresses 48..52, then a single done pulse.
- a_base=1022, M=4 → rd_addr_a sequence 1022,1023,0,1. d_base=1023 → write addresses 1023,0,1,2.
- cmd_n_dim=0 → one-cycle done with cmd_err=1, no strobes, masks unchanged. cmd_valid held during busy → no second accept until after done.
- Writebacks delayed arbitrarily (gaps of 0–7 cycles) → done only after the M-th writeback. A writeback while IDLE → no effect.
